hash_table_core: RTL
====================

Name: hash_table_core

Overview:
- Parametrised key/value hash table engine; next generation of the tt_um_save_buffer_hash_table datapath.
- Generalised in key width, value width and table depth.
- Adds linear-probe collision handling, tombstone delete, whole-table clear and an occupancy count.
- Sits behind the pin-level top wrapper; talks over a valid/ready request channel and a pulsed response channel.

Parameters:
- KEY_W, 8: key width in bits.
- VAL_W, 8: value width in bits.
- SLOT_BITS, 3: log2 of slot count; NUM_SLOTS = 2**SLOT_BITS.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: engine idle, can accept a request.
- req_op, input, 2: 00 LOOKUP, 01 INSERT, 10 DELETE, 11 CLEAR.
- req_key, input, KEY_W: request key.
- req_value, input, VAL_W: insert value.
- resp_valid, output, 1: one-cycle response pulse.
- resp_status, output, 2: 00 OK, 01 MISS, 10 FULL, 11 UPDATED.
- resp_value, output, VAL_W: response value.
- occupancy, output, SLOT_BITS+1: count of LIVE slots.

Behaviour:
- Reset (asynchronous):
  - All slots go to EMPTY.
  - FSM goes to IDLE.
  - req_ready=1, resp_valid=0, resp_status=00, resp_value=0, occupancy=0.
  - Reset mid-probe abandons the operation with no response.
- Slot state: EMPTY, LIVE or TOMB, plus key and value storage.
- Hash: XOR-fold of req_key into SLOT_BITS-bit chunks. The last chunk is zero-padded at the MSBs.
- Probe sequence: h, h+1, ... modulo NUM_SLOTS (wraps). One slot is examined per cycle. At most NUM_SLOTS probes.
- Handshake:
  - Accept on a rising edge with req_valid & req_ready.
  - Key, value and op are latched at the accept edge.
  - req_ready=0 outside IDLE; requests are ignored while busy.
- FSM states:
  - IDLE -> PROBE on accept of LOOKUP, INSERT or DELETE.
  - IDLE -> IDLE on accept of CLEAR. All slots go EMPTY, occupancy=0, resp OK at the next edge.
  - PROBE -> IDLE on a terminating probe. The response registers are loaded on that same edge.
- Timing:
  - resp_valid is high for exactly one cycle, starting N edges after the accept edge, where N = probes taken (N >= 1).
  - req_ready returns high in that same cycle, so back-to-back requests are legal.
  - There is no response backpressure.
- LOOKUP:
  - LIVE slot with matching key: OK, resp_value = stored value.
  - EMPTY slot: MISS.
  - TOMB slot: skip and continue.
  - NUM_SLOTS probes with no match: MISS.
- DELETE:
  - Match: slot becomes TOMB, OK, resp_value = old value, occupancy decrements.
  - Otherwise MISS, as for LOOKUP.
- INSERT:
  - Remember the first TOMB or EMPTY slot seen.
  - Match on a LIVE key: overwrite the value, UPDATED, resp_value = previous value, occupancy unchanged.
  - Terminate on EMPTY or after NUM_SLOTS probes.
  - If a free slot was remembered: write LIVE into it, OK, resp_value = inserted value, occupancy increments.
  - Else: FULL, no state change.
- resp_value = 0 for MISS, FULL and CLEAR.
- occupancy saturates by construction (max NUM_SLOTS); it never wraps.

Decomposition:
- hash_table_pkg contains:
  - op enum (LOOKUP, INSERT, DELETE, CLEAR).
  - status enum (OK, MISS, FULL, UPDATED).
  - slot-state enum (EMPTY, LIVE, TOMB).
  - FSM state enum (IDLE, PROBE).
- Sub-module hash_fold: combinational XOR-fold, parametrised by KEY_W and SLOT_BITS.

Test Plan:
All scenarios use the defaults KEY_W=8, VAL_W=8, SLOT_BITS=3.
Reference hashes: 0x5A->0, 0x08->1, 0x01->1, 0x40->1.
- After reset: req_ready=1, occupancy=0. LOOKUP 0x5A -> MISS, resp_value=0, resp_valid at edge 1 after accept.
- INSERT 0x08/0xAA then INSERT 0x01/0xBB (collision; 0x01 lands in slot 2, 2 probes). LOOKUP 0x01 -> OK 0xBB at edge 2. occupancy=2.
- INSERT 0x08/0xCC -> UPDATED, resp_value=0xAA, occupancy=2. LOOKUP 0x08 -> OK 0xCC.
- DELETE 0x08 -> OK 0xCC, occupancy=1. LOOKUP 0x01 -> OK 0xBB after 2 probes (crosses tombstone). INSERT 0x40/0x77 -> OK after 3 probes, reuses slot 1, occupancy=2.
- Insert 8 distinct keys -> occupancy=8. A 9th new key -> FULL after 8 probes. LOOKUP of an absent key -> MISS after 8 probes. CLEAR -> OK, occupancy=0.
- Drive rst_n=0 during PROBE -> immediately resp_valid=0, req_ready=1, occupancy=0. A subsequent LOOKUP of a previously inserted key -> MISS.

Source files
------------

// File: rtl/hash_table_pkg.sv
// Shared types for the hash table engine: request ops, response status,
// per-slot state and the engine FSM encoding.
package hash_table_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_MISS    = 2'b01,
        ST_FULL    = 2'b10,
        ST_UPDATED = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'b00,
        SLOT_LIVE  = 2'b01,
        SLOT_TOMB  = 2'b10
    } slot_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_PROBE = 1'b1
    } fsm_e;

endpackage

// File: rtl/hash_fold.sv
// XOR-fold of a key into SLOT_BITS-wide chunks; the top chunk is zero-padded.
module hash_fold #(
    parameter int KEY_W     = 8,
    parameter int SLOT_BITS = 3
) (
    input  logic [KEY_W-1:0]     key,
    output logic [SLOT_BITS-1:0] hash
);

    localparam int CHUNKS = (KEY_W + SLOT_BITS - 1) / SLOT_BITS;
    localparam int PAD_W  = CHUNKS * SLOT_BITS;

    logic [PAD_W-1:0] padded;

    always_comb begin
        padded = PAD_W'(key);
        hash   = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            hash = hash ^ padded[i*SLOT_BITS +: SLOT_BITS];
        end
    end

endmodule

// File: rtl/hash_table_core.sv
// Key/value hash table engine: linear probing, tombstone delete, clear,
// one slot examined per cycle, one-cycle response pulse.
module hash_table_core
    import hash_table_pkg::*;
#(
    parameter int KEY_W     = 8,
    parameter int VAL_W     = 8,
    parameter int SLOT_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [KEY_W-1:0]     req_key,
    input  logic [VAL_W-1:0]     req_value,
    output logic                 resp_valid,
    output logic [1:0]           resp_status,
    output logic [VAL_W-1:0]     resp_value,
    output logic [SLOT_BITS:0]   occupancy
);

    localparam int NUM_SLOTS = 2 ** SLOT_BITS;
    // probe_cnt value while the NUM_SLOTS-th slot is being examined
    localparam logic [SLOT_BITS-1:0] LAST_PROBE = '1;

    fsm_e                 state, state_nx;
    slot_e                slot_state [NUM_SLOTS];
    logic [KEY_W-1:0]     slot_key   [NUM_SLOTS];
    logic [VAL_W-1:0]     slot_val   [NUM_SLOTS];

    op_e                  op_q;
    logic [KEY_W-1:0]     key_q;
    logic [VAL_W-1:0]     val_q;
    logic [SLOT_BITS-1:0] probe_idx, probe_cnt, free_idx;
    logic                 free_found;
    logic [SLOT_BITS-1:0] hash;

    logic                 accept;
    slot_e                cur_state;
    logic                 cur_hit, cur_free, last;
    logic                 done, wr_en, occ_inc, occ_dec;
    status_e              done_status;
    logic [VAL_W-1:0]     done_value, wr_val;
    logic [SLOT_BITS-1:0] wr_idx;
    slot_e                wr_state;

    hash_fold #(.KEY_W(KEY_W), .SLOT_BITS(SLOT_BITS)) u_hash (
        .key  (req_key),
        .hash (hash)
    );

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_nx    = state;
        cur_state   = slot_state[probe_idx];
        cur_hit     = (cur_state == SLOT_LIVE) && (slot_key[probe_idx] == key_q);
        cur_free    = (cur_state != SLOT_LIVE);
        last        = (probe_cnt == LAST_PROBE);
        done        = 1'b0;
        done_status = ST_MISS;
        done_value  = '0;
        wr_en       = 1'b0;
        wr_idx      = probe_idx;
        wr_state    = SLOT_LIVE;
        wr_val      = val_q;
        occ_inc     = 1'b0;
        occ_dec     = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept && (op_e'(req_op) != OP_CLEAR)) state_nx = S_PROBE;
            end
            S_PROBE: begin
                if (op_q == OP_INSERT) begin
                    if (cur_hit) begin
                        done        = 1'b1;
                        done_status = ST_UPDATED;
                        done_value  = slot_val[probe_idx];
                        wr_en       = 1'b1;
                    end else if (cur_state == SLOT_EMPTY || last) begin
                        done = 1'b1;
                        // earliest free slot on the probe path wins, including this one
                        if (free_found || cur_free) begin
                            done_status = ST_OK;
                            done_value  = val_q;
                            wr_en       = 1'b1;
                            wr_idx      = free_found ? free_idx : probe_idx;
                            occ_inc     = 1'b1;
                        end else begin
                            done_status = ST_FULL;
                        end
                    end
                end else begin
                    if (cur_hit) begin
                        done        = 1'b1;
                        done_status = ST_OK;
                        done_value  = slot_val[probe_idx];
                        if (op_q == OP_DELETE) begin
                            wr_en    = 1'b1;
                            wr_state = SLOT_TOMB;
                            wr_val   = slot_val[probe_idx];
                            occ_dec  = 1'b1;
                        end
                    end else if (cur_state == SLOT_EMPTY || last) begin
                        done        = 1'b1;
                        done_status = ST_MISS;
                    end
                end
                if (done) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            resp_valid  <= 1'b0;
            resp_status <= ST_OK;
            resp_value  <= '0;
            occupancy   <= '0;
            op_q        <= OP_LOOKUP;
            key_q       <= '0;
            val_q       <= '0;
            probe_idx   <= '0;
            probe_cnt   <= '0;
            free_idx    <= '0;
            free_found  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_state[i] <= SLOT_EMPTY;
                slot_key[i]   <= '0;
                slot_val[i]   <= '0;
            end
        end else begin
            state      <= state_nx;
            resp_valid <= 1'b0;

            if (accept) begin
                op_q       <= op_e'(req_op);
                key_q      <= req_key;
                val_q      <= req_value;
                probe_idx  <= hash;
                probe_cnt  <= '0;
                free_found <= 1'b0;
                if (op_e'(req_op) == OP_CLEAR) begin
                    for (int i = 0; i < NUM_SLOTS; i++) slot_state[i] <= SLOT_EMPTY;
                    occupancy   <= '0;
                    resp_valid  <= 1'b1;
                    resp_status <= ST_OK;
                    resp_value  <= '0;
                end
            end

            if (state == S_PROBE) begin
                if (done) begin
                    resp_valid  <= 1'b1;
                    resp_status <= done_status;
                    resp_value  <= done_value;
                    if (wr_en) begin
                        slot_state[wr_idx] <= wr_state;
                        slot_key[wr_idx]   <= key_q;
                        slot_val[wr_idx]   <= wr_val;
                    end
                    if (occ_inc)      occupancy <= occupancy + 1'b1;
                    else if (occ_dec) occupancy <= occupancy - 1'b1;
                end else begin
                    probe_idx <= probe_idx + 1'b1;
                    probe_cnt <= probe_cnt + 1'b1;
                    if (cur_free && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= probe_idx;
                    end
                end
            end
        end
    end

endmodule
